vc_flit_fifo: RTL
=================

# vc_flit_fifo

Multi-channel flit buffer: NUM_VC independent FIFOs, each 2**ADDR_WIDTH entries deep, sharing one write port, one read port and one simple dual-port RAM. It sits at router input ports, where one physical link carries flits of several virtual channels. Unlike the single-queue buffer, it tracks exact full and empty per channel, rejects overflow and underflow without corrupting state, and exports per-channel occupancy for credit flow control.

## Interface
- DATA_WIDTH, 32, flit width in bits
- ADDR_WIDTH, 4, log2 of per-VC depth; DEPTH = 2**ADDR_WIDTH
- NUM_VC, 4, number of virtual channels, ≥1
- AF_LEVEL, 2, almost_full asserts when free slots ≤ AF_LEVEL; range 0..DEPTH-1
- Derived: VC_W = max(1, clog2(NUM_VC)); CNT_W = ADDR_WIDTH+1

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- wr_en  in  1  write request
- wr_vc  in  VC_W  target channel of write
- wr_data  in  DATA_WIDTH  flit to store
- rd_en  in  1  read request
- rd_vc  in  VC_W  source channel of read
- rd_data  out  DATA_WIDTH  registered read flit
- rd_valid  out  1  rd_data carries a flit popped on the previous edge
- not_empty  out  NUM_VC  per-VC count ≠ 0
- full  out  NUM_VC  per-VC count == DEPTH
- almost_full  out  NUM_VC  per-VC (DEPTH − count) ≤ AF_LEVEL
- count  out  NUM_VC*CNT_W  per-VC occupancy, VC i at bits [i*CNT_W +: CNT_W]
- overflow_err  out  1  sticky: write rejected because the channel was full
- underflow_err  out  1  sticky: read rejected because the channel was empty

## Operation
- Per-VC state: wr_ptr, rd_ptr (ADDR_WIDTH bits, wrap modulo DEPTH) and cnt (CNT_W bits, 0..DEPTH). The RAM address is {vc, ptr}, so the RAM holds NUM_VC*DEPTH words.
- Write accepted iff wr_en && (!full[wr_vc] || (rd_acc && rd_vc == wr_vc)). On acceptance, RAM[{wr_vc, wr_ptr}] ← wr_data and that channel's wr_ptr increments.
- Read accepted (rd_acc) iff rd_en && not_empty[rd_vc]. On acceptance, rd_data ← RAM[{rd_vc, rd_ptr}], rd_ptr increments and rd_valid = 1 next cycle. Otherwise rd_valid = 0 and rd_data holds its previous value.
- Count update per VC:
  - accepted write only: +1
  - accepted read only: −1
  - both on the same VC: unchanged
  - writes and reads on different VCs update independently
- No bypass: a read of an empty VC is rejected even when the same cycle writes that VC; the count becomes 1.
- Full VC with a simultaneous read of the same VC: write and read address the same RAM word. The RAM is read-first, so rd_data is the old flit, the new flit is stored and the count stays at DEPTH.
- A rejected write sets overflow_err; a rejected read sets underflow_err. Neither changes any pointer, count or RAM word. Both flags clear only on reset.
- wr_vc or rd_vc ≥ NUM_VC with its enable high counts as a rejected access of the matching kind and sets the matching error flag.
- Reset values: all pointers and counts 0; rd_data 0; rd_valid 0; not_empty 0; full 0; both error flags 0. almost_full[i] = 1 only when DEPTH ≤ AF_LEVEL. Reset mid-operation discards all contents; RAM contents are don't-care.

## Timing
- Write-to-visible latency 1: not_empty, count, full and almost_full reflect a write on the edge that accepts it.
- Read latency 1: rd_en sampled at edge N gives rd_data and rd_valid valid after edge N, for one cycle.
- Status outputs are decoded combinationally from registered counts only, with no path from wr_en or rd_en. The upstream must therefore sample full or almost_full one cycle ahead; AF_LEVEL ≥ 1 covers one in-flight flit.
- Back-to-back reads of one VC sustain 1 flit/cycle; interleaved VCs sustain 1 flit/cycle.

## Structure
- Sub-module vc_flit_fifo_ram: simple dual-port, read-first, registered read, with depth NUM_VC*DEPTH. It replaces the direct use of the older queue RAM so that read-first behaviour is guaranteed.
- The shared NoC package holds the DATA_WIDTH default (flit width), the NUM_VC default and a clog2 function; CNT_W and VC_W are local.
- Per-VC control uses a generate loop over NUM_VC, with no separate control module.

## Test plan
- NUM_VC=4, ADDR_WIDTH=2: write 0xA0..0xA3 to VC2, then read VC2 four times → rd_data 0xA0,0xA1,0xA2,0xA3 in order, count[2] 4→0, other VCs untouched.
- Fill VC1 to 4, fifth write 0xFF → full[1]=1, overflow_err=1, count stays 4, the following reads return the original four flits.
- VC0 full, simultaneous write 0x55 and read of VC0 → rd_data = oldest flit, count stays 4, 0x55 is returned as the fourth subsequent read.
- Read of empty VC3 with a same-cycle write 0x77 to VC3 → rd_valid=0, underflow_err=1, count[3]=1, next read returns 0x77.
- Interleaved random writes and reads on all VCs for 10k cycles against a per-VC scoreboard → no mismatches, and almost_full asserts exactly at count ≥ DEPTH−AF_LEVEL.
- Assert rst_n mid-traffic → all counts 0, rd_valid 0, both error flags 0 asynchronously, and normal operation resumes on the first edge after release.

Source files
------------

// File: rtl/vc_flit_fifo_pkg.sv
// Shared NoC definitions used by the virtual-channel flit buffer.
//   FLIT_W     : default flit width in bits
//   NUM_VC_DEF : default number of virtual channels
//   clog2()    : ceil(log2(v)), returns 0 for v <= 1
package vc_flit_fifo_pkg;

  localparam int FLIT_W     = 32;
  localparam int NUM_VC_DEF = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/vc_flit_fifo_ram.sv
// Simple dual-port RAM, read-first, registered read port.
//   clk, rst_n   : clock / async active-low reset (read register only)
//   we/waddr/wdata : write port
//   re/raddr     : read request; rdata updates on the edge that samples re
//   rdata        : registered read data, holds when re is low
// A write and a read to the same word on one edge return the old word.
module vc_flit_fifo_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_W     = 6,
  parameter int WORDS      = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [WORDS];
  logic [DATA_WIDTH-1:0] rdata_d, rdata_q;

  // Storage array carries no reset; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Combinational read of the pre-edge array gives read-first behaviour.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/vc_flit_fifo.sv
// Multi-VC flit buffer: NUM_VC independent FIFOs of 2**ADDR_WIDTH flits
// sharing one write port, one read port and one RAM addressed {vc, ptr}.
//   clk, rst_n        : clock / async active-low reset
//   wr_en/wr_vc/wr_data : write request to channel wr_vc
//   rd_en/rd_vc       : read request from channel rd_vc
//   rd_data/rd_valid  : registered flit, valid one cycle after the read
//   not_empty/full/almost_full : per-VC status decoded from registered counts
//   count             : per-VC occupancy, VC i at [i*CNT_W +: CNT_W]
//   overflow_err/underflow_err : sticky rejected-write / rejected-read flags
module vc_flit_fifo import vc_flit_fifo_pkg::*; #(
  parameter  int DATA_WIDTH = FLIT_W,
  parameter  int ADDR_WIDTH = 4,
  parameter  int NUM_VC     = NUM_VC_DEF,
  parameter  int AF_LEVEL   = 2,
  localparam int VC_W       = (clog2(NUM_VC) < 1) ? 1 : clog2(NUM_VC),
  localparam int CNT_W      = ADDR_WIDTH + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [VC_W-1:0]         wr_vc,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  input  logic [VC_W-1:0]         rd_vc,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic [NUM_VC-1:0]       not_empty,
  output logic [NUM_VC-1:0]       full,
  output logic [NUM_VC-1:0]       almost_full,
  output logic [NUM_VC*CNT_W-1:0] count,
  output logic                    overflow_err,
  output logic                    underflow_err
);

  localparam int DEPTH     = 1 << ADDR_WIDTH;
  localparam int RAM_AW    = VC_W + ADDR_WIDTH;
  localparam int RAM_WORDS = NUM_VC * DEPTH;

  logic [NUM_VC-1:0][ADDR_WIDTH-1:0] wr_ptr_all, rd_ptr_all;

  logic                  wr_acc, rd_acc, vc_match;
  logic                  wr_full_sel, rd_ne_sel, wr_vc_ok;
  logic [ADDR_WIDTH-1:0] wr_ptr_sel, rd_ptr_sel;
  logic                  rd_valid_d, rd_valid_q;
  logic                  overflow_d, overflow_q, underflow_d, underflow_q;

  // Select the addressed channel's state. An out-of-range VC matches no
  // channel, so its selects stay at their defaults (not empty = 0) and the
  // access is rejected.
  always_comb begin
    wr_ptr_sel  = '0;
    rd_ptr_sel  = '0;
    wr_full_sel = 1'b0;
    rd_ne_sel   = 1'b0;
    wr_vc_ok    = 1'b0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (wr_vc == VC_W'(i)) begin
        wr_ptr_sel  = wr_ptr_all[i];
        wr_full_sel = full[i];
        wr_vc_ok    = 1'b1;
      end
      if (rd_vc == VC_W'(i)) begin
        rd_ptr_sel = rd_ptr_all[i];
        rd_ne_sel  = not_empty[i];
      end
    end
    vc_match = (wr_vc == rd_vc);
    rd_acc   = rd_en && rd_ne_sel;
    // A full channel still takes a write when the same edge pops it.
    wr_acc   = wr_en && wr_vc_ok && (!wr_full_sel || (rd_acc && vc_match));

    rd_valid_d  = rd_acc;
    overflow_d  = overflow_q  | (wr_en && !wr_acc);
    underflow_d = underflow_q | (rd_en && !rd_acc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign rd_valid      = rd_valid_q;
  assign overflow_err  = overflow_q;
  assign underflow_err = underflow_q;

  for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
    logic                  wr_hit, rd_hit;
    logic [ADDR_WIDTH-1:0] wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
    logic [CNT_W-1:0]      cnt_d, cnt_q;

    always_comb begin
      wr_hit   = wr_acc && (wr_vc == VC_W'(g));
      rd_hit   = rd_acc && (rd_vc == VC_W'(g));
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(wr_hit);
      rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(rd_hit);
      cnt_d    = cnt_q;
      if (wr_hit && !rd_hit)      cnt_d = cnt_q + CNT_W'(1);
      else if (rd_hit && !wr_hit) cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
      end
    end

    assign wr_ptr_all[g]              = wr_ptr_q;
    assign rd_ptr_all[g]              = rd_ptr_q;
    assign not_empty[g]               = (cnt_q != '0);
    assign full[g]                    = (cnt_q == CNT_W'(DEPTH));
    assign almost_full[g]             = ((CNT_W'(DEPTH) - cnt_q) <= CNT_W'(AF_LEVEL));
    assign count[g*CNT_W +: CNT_W]    = cnt_q;
  end

  vc_flit_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (RAM_AW),
    .WORDS      (RAM_WORDS)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc),
    .waddr ({wr_vc, wr_ptr_sel}),
    .wdata (wr_data),
    .re    (rd_acc),
    .raddr ({rd_vc, rd_ptr_sel}),
    .rdata (rd_data)
  );

endmodule
